// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, word-addressed instruction
// memory, branch redirect / hazard freeze handling and a fetch counter.
//
// Ports:
//   clk          pipeline clock, rising edge active
//   rst          asynchronous active-high reset (PC, fetch counter)
//   freeze       hazard stall, PC holds this cycle
//   branch_taken EX-stage branch resolved taken (overrides freeze)
//   branch_addr  branch target from EX, low two bits dropped
//   imem_we      program-load write enable
//   imem_waddr   program-load byte address
//   imem_wdata   program-load instruction word
//   pc_out       PC+4 of the current fetch, to IF/ID
//   instruction  word at the current PC, to IF/ID
//   flush        IF/ID flush request (same cycle as redirect)
//   fetch_count  number of edges on which PC was loaded
module if_stage #(
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] pc_out,
  output logic [31:0] instruction,
  output logic        flush,
  output logic [31:0] fetch_count
);

  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0] r_pc;
  logic [31:0] r_fetch_count;
  logic [31:0] r_imem [IMEM_WORDS];

  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_pc_next;
  logic          w_pc_load;
  logic [AW-1:0] w_rd_idx;
  logic          w_rd_ok;
  logic [AW-1:0] w_wr_idx;
  logic          w_wr_ok;
  logic          w_unused;

  // Byte-offset bits of both addresses are ignored by design.
  assign w_unused = ^{imem_waddr[1:0], branch_addr[1:0]};

  assign w_pc_plus4 = r_pc + 32'd4;

  // A taken branch wins over a stall: the redirect must not be lost.
  assign w_pc_load = branch_taken | ~freeze;
  assign w_pc_next = branch_taken ? {branch_addr[31:2], 2'b00}
                                  : w_pc_plus4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else if (w_pc_load) begin
      r_pc          <= w_pc_next;
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  // A word index is in range only when every bit above the array
  // index is zero; otherwise reads return 0 and writes are dropped.
  assign w_rd_idx = r_pc[AW+1:2];
  assign w_rd_ok  = (r_pc[31:AW+2] == '0);
  assign w_wr_idx = imem_waddr[AW+1:2];
  assign w_wr_ok  = (imem_waddr[31:AW+2] == '0);

  // Memory has no reset so a program can be loaded while rst is held.
  always_ff @(posedge clk) begin
    if (imem_we && w_wr_ok) begin
      r_imem[w_wr_idx] <= imem_wdata;
    end
  end

  assign instruction = w_rd_ok ? r_imem[w_rd_idx] : 32'h0000_0000;
  assign pc_out      = w_pc_plus4;
  assign flush       = branch_taken;
  assign fetch_count = r_fetch_count;

endmodule
